camera_handoff_controller: RTL

//  Sequences the two camera buffers of the space-station recorder so one camera is always filming.

---
 rtl/camera_handoff_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/camera_handoff_controller.sv
// Two-camera film/standby sequencer: keeps exactly one camera filming, hands off on fill level,
// and drains the idle-full buffer by download (when requested) or flush.
module camera_handoff_controller #(
   parameter int DEFAULT_CAM = 0,
   parameter int STANDBY_PCT = 80,
   parameter int FILM_PCT    = 90,
   parameter int FLUSH_PCT   = 50
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] cam1_level,
   input  logic [6:0] cam2_level,
   input  logic       download1,
   input  logic       download2,
   output logic       cam1_standby,
   output logic       cam1_film,
   output logic       cam2_standby,
   output logic       cam2_film,
   output logic       empty_buffer1,
   output logic       empty_buffer2,
   output logic       pause_buffer1,
   output logic       pause_buffer2,
   output logic [1:0] done1,
   output logic [1:0] done2,
   output logic       overrun
);

   typedef enum logic [2:0] {IDLE, STANDBY, FILM, HOLD, DRAIN} cam_state_t;

   localparam logic [6:0] STANDBY_LVL = 7'(STANDBY_PCT);
   localparam logic [6:0] FILM_LVL    = 7'(FILM_PCT);
   localparam logic [6:0] FLUSH_LVL   = 7'(FLUSH_PCT);
   localparam logic [6:0] FULL_LVL    = 7'd100;

   cam_state_t state_reg [2];
   cam_state_t state_next [2];
   logic       latch_reg [2];
   logic       latch_next [2];
   logic       stall_reg [2];
   logic       stall_next [2];
   logic [1:0] done_reg [2];
   logic [1:0] done_next [2];
   logic       overrun_reg;
   logic       overrun_next;

   logic [6:0] lvl [2];
   logic       dl [2];
   logic [1:0] standby_vec;
   logic [1:0] film_vec;
   logic [1:0] empty_vec;
   logic [1:0] pause_vec;

   always_comb begin
      lvl[0] = (cam1_level > FULL_LVL) ? FULL_LVL : cam1_level;
      lvl[1] = (cam2_level > FULL_LVL) ? FULL_LVL : cam2_level;
      dl[0]  = download1;
      dl[1]  = download2;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            state_reg[i] <= (i == DEFAULT_CAM) ? FILM : IDLE;
            latch_reg[i] <= 1'b0;
            stall_reg[i] <= 1'b0;
            done_reg[i]  <= 2'b00;
         end
         overrun_reg <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state_reg[i] <= state_next[i];
            latch_reg[i] <= latch_next[i];
            stall_reg[i] <= stall_next[i];
            done_reg[i]  <= done_next[i];
         end
         overrun_reg <= overrun_next;
      end
   end

   // Both cameras evaluate from the same registered states, so a handoff flips both on one edge.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_next[i] = state_reg[i];
         latch_next[i] = latch_reg[i];
         stall_next[i] = 1'b0;
         done_next[i]  = 2'b00;
         case (state_reg[i])
            IDLE: begin
               if (state_reg[i ^ 1] == FILM && lvl[i ^ 1] >= STANDBY_LVL)
                  state_next[i] = STANDBY;
            end
            STANDBY: begin
               if (state_reg[i ^ 1] == FILM && lvl[i ^ 1] >= FILM_LVL)
                  state_next[i] = FILM;
            end
            FILM: begin
               if (dl[i])
                  latch_next[i] = 1'b1;
               if (lvl[i] >= FILM_LVL && state_reg[i ^ 1] == STANDBY)
                  state_next[i] = HOLD;
               else if (lvl[i] >= FULL_LVL)
                  stall_next[i] = 1'b1;
            end
            HOLD: begin
               // A download request arriving this cycle beats a simultaneous flush threshold.
               if (latch_reg[i] || dl[i]) begin
                  latch_next[i] = 1'b1;
                  state_next[i] = DRAIN;
               end else if (state_reg[i ^ 1] == FILM && lvl[i ^ 1] >= FLUSH_LVL) begin
                  state_next[i] = DRAIN;
               end
            end
            DRAIN: begin
               if (lvl[i] == 7'd0) begin
                  state_next[i] = IDLE;
                  latch_next[i] = 1'b0;
                  done_next[i]  = latch_reg[i] ? 2'b01 : 2'b10;
               end
            end
            default: state_next[i] = IDLE;
         endcase
      end
      overrun_next = overrun_reg | stall_next[0] | stall_next[1];
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         standby_vec[i] = (state_reg[i] == STANDBY);
         film_vec[i]    = (state_reg[i] == FILM);
         empty_vec[i]   = (state_reg[i] == DRAIN);
         pause_vec[i]   = (state_reg[i] == IDLE) || (state_reg[i] == STANDBY) ||
                          (state_reg[i] == HOLD) || (state_reg[i] == FILM && stall_reg[i]);
      end
   end

   assign cam1_standby  = standby_vec[0];
   assign cam2_standby  = standby_vec[1];
   assign cam1_film     = film_vec[0];
   assign cam2_film     = film_vec[1];
   assign empty_buffer1 = empty_vec[0];
   assign empty_buffer2 = empty_vec[1];
   assign pause_buffer1 = pause_vec[0];
   assign pause_buffer2 = pause_vec[1];
   assign done1         = done_reg[0];
   assign done2         = done_reg[1];
   assign overrun       = overrun_reg;

endmodule
